// File: rtl/s27_resp_compactor.sv
// MISR response compactor for the s27 core: folds qualified G17 bits into a signature and checks it against GOLDEN.
// Optional G17 transition counter enabled by defining S27_RESP_TOGGLE_CNT_EN.
module s27_resp_compactor #(
  parameter int                SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = 16'hB400,
  parameter int                LEN_W = 16
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic [SIG_W-1:0] SEED,
  input  logic [SIG_W-1:0] GOLDEN,
  input  logic             G17,
  input  logic             VALID_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIG,
  output logic [LEN_W-1:0] CNT,
  output logic [LEN_W-1:0] TOGGLES,
  output logic [1:0]       STATE
);

  // Handshake: START is a level request honoured only in IDLE (ignored while BUSY);
  // VALID_IN qualifies G17 in RUN with no backpressure, a low VALID_IN simply stalls.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [SIG_W-1:0] sig_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;

  logic [SIG_W-1:0] sig_d;
  logic [LEN_W-1:0] cnt_d;

  assign sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : {SIG_W{1'b0}})
               ^ {{(SIG_W-1){1'b0}}, G17};
  assign cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

`ifdef S27_RESP_TOGGLE_CNT_EN
  logic [LEN_W-1:0] tog_q;
  logic             prev_q;
  logic             have_prev_q;
`endif

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      sig_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
`ifdef S27_RESP_TOGGLE_CNT_EN
      tog_q       <= '0;
      prev_q      <= 1'b0;
      have_prev_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            sig_q   <= SEED;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            len_q   <= LEN;
            busy_q  <= 1'b1;
            state_q <= (LEN == '0) ? ST_CHECK : ST_RUN;
`ifdef S27_RESP_TOGGLE_CNT_EN
            tog_q       <= '0;
            have_prev_q <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (VALID_IN) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
`ifdef S27_RESP_TOGGLE_CNT_EN
            // History spans stalls; only qualified samples are compared.
            if (have_prev_q && (G17 != prev_q)) tog_q <= tog_q + {{(LEN_W-1){1'b0}}, 1'b1};
            prev_q      <= G17;
            have_prev_q <= 1'b1;
`endif
            if (cnt_d == len_q) state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          pass_q  <= (sig_q == GOLDEN);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign PASS  = pass_q;
  assign SIG   = sig_q;
  assign CNT   = cnt_q;
  assign STATE = state_q;
`ifdef S27_RESP_TOGGLE_CNT_EN
  assign TOGGLES = tog_q;
`else
  assign TOGGLES = '0;
`endif

endmodule

// File: tb/tb_s27_resp_compactor.sv
// Bench for s27_resp_compactor: directed and random sessions, arithmetic MISR model, DONE-driven scoreboard.
module tb_s27_resp_compactor;

  localparam logic [15:0] POLY = 16'hB400;

  logic        CK;
  logic        RSTN;
  logic        START;
  logic [15:0] LEN;
  logic [15:0] SEED;
  logic [15:0] GOLDEN;
  logic        G17;
  logic        VALID_IN;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [15:0] SIG;
  logic [15:0] CNT;
  logic [15:0] TOGGLES;
  logic [1:0]  state_dbg;

  s27_resp_compactor dut (
    .CK(CK), .RSTN(RSTN), .START(START), .LEN(LEN), .SEED(SEED), .GOLDEN(GOLDEN),
    .G17(G17), .VALID_IN(VALID_IN), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .SIG(SIG), .CNT(CNT), .TOGGLES(TOGGLES), .STATE(state_dbg)
  );

  // clock / reset
  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct packed {
    logic [15:0] sig;
    logic        pass;
    logic [15:0] cnt;
    logic [15:0] tog;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signature treated as a number: double it, reduce by the feedback polynomial on overflow, add the bit.
  function automatic logic [15:0] m_step(input logic [15:0] s, input logic b);
    int v;
    v = int'(s) * 2;
    if (v > 65535) v = (v - 65536) ^ int'(POLY);
    v = v ^ int'(b);
    return v[15:0];
  endfunction

  function automatic logic [15:0] m_tog(input int n_toggles);
`ifdef S27_RESP_TOGGLE_CNT_EN
    return 16'(n_toggles);
`else
    return 16'(n_toggles * 0);
`endif
  endfunction

  // scoreboard monitor
  always @(negedge CK) begin
    if (RSTN && DONE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(DONE), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sig",     32'(SIG),     32'(e.sig));
        chk("pass",    32'(PASS),    32'(e.pass));
        chk("cnt",     32'(CNT),     32'(e.cnt));
        chk("toggles", 32'(TOGGLES), 32'(e.tog));
      end
    end
  end

  // driver: called at a negedge, returns at the negedge where DONE is visible
  // gsel: 0 = use golden_in, 1 = golden equals model signature, 2 = random golden
  task automatic run_session(input logic [15:0] seed, input int len, input int gsel,
                             input logic [15:0] golden_in, input int stall_pct,
                             input bit use_pat, input logic [31:0] pat);
    logic [15:0] s;
    logic        b;
    logic        prev_b;
    int          tog;
    int          stalls;
    int          edges;
    int          guard;
    exp_t        e;
    START = 1'b1;
    LEN   = 16'(len);
    SEED  = seed;
    @(posedge CK);
    edges = 1;
    @(negedge CK);
    START = 1'b0;
    chk("busy_at_start", 32'(BUSY), 32'd1);
    chk("pass_cleared",  32'(PASS), 32'd0);
    chk("sig_seeded",    32'(SIG),  32'(seed));
    s = seed; tog = 0; stalls = 0; prev_b = 1'b0;
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(99) < stall_pct) begin
        VALID_IN = 1'b0;
        G17      = 1'($urandom_range(1));
        START    = 1'($urandom_range(1));
        LEN      = 16'($urandom_range(3));
        SEED     = 16'($urandom);
        @(posedge CK); edges++; stalls++;
        @(negedge CK);
      end
      b = (use_pat && i < 32) ? pat[i] : 1'($urandom_range(1));
      VALID_IN = 1'b1;
      G17      = b;
      START    = 1'($urandom_range(1));
      @(posedge CK); edges++;
      @(negedge CK);
      if (i > 0 && b != prev_b) tog++;
      prev_b = b;
      s = m_step(s, b);
    end
    VALID_IN = 1'b0;
    START    = 1'b0;
    case (gsel)
      0:       GOLDEN = golden_in;
      1:       GOLDEN = s;
      default: GOLDEN = 16'($urandom);
    endcase
    e.sig  = s;
    e.pass = (s == GOLDEN);
    e.cnt  = 16'(len);
    e.tog  = m_tog(tog);
    exp_q.push_back(e);
    guard = 0;
    while (!DONE && guard < 8) begin
      @(posedge CK); edges++;
      @(negedge CK);
      guard++;
    end
    chk("done_seen", 32'(DONE),  32'd1);
    chk("latency",   32'(edges), 32'(len + 2 + stalls));
    chk("busy_done", 32'(BUSY),  32'd0);
  endtask

  logic [15:0] s4;
  int          exp_cnt4[5];
  logic        valid4[5];
  logic        bits4[5];

  initial begin
    RSTN = 1'b0; START = 1'b0; LEN = '0; SEED = '0; GOLDEN = '0; G17 = 1'b0; VALID_IN = 1'b0;
    repeat (2) @(posedge CK);
    @(negedge CK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_pass", 32'(PASS), 32'd0);
    chk("rst_sig",  32'(SIG),  32'd0);
    chk("rst_cnt",  32'(CNT),  32'd0);
    chk("rst_tog",  32'(TOGGLES), 32'd0);
    RSTN = 1'b1;
    @(negedge CK);

    // shifting zeros through a unit seed
    run_session(16'h0001, 4, 0, 16'h0010, 0, 1'b1, 32'h0);
    chk("t1_sig", 32'(SIG), 32'h0010);
    chk("t1_pass", 32'(PASS), 32'd1);
    // MSB shifted out applies the polynomial
    run_session(16'h8000, 1, 0, 16'h0000, 0, 1'b1, 32'h0);
    chk("t2_sig", 32'(SIG), 32'hB400);
    chk("t2_pass", 32'(PASS), 32'd0);
    run_session(16'h0000, 1, 2, 16'h0000, 0, 1'b1, 32'h1);
    chk("t3_sig", 32'(SIG), 32'h0001);
    run_session(16'h1234, 0, 0, 16'h1234, 0, 1'b0, 32'h0);
    chk("t3_len0_pass", 32'(PASS), 32'd1);
    // qualified G17 sequence 0,1,1,0,1
    run_session(16'h5A5A, 5, 1, 16'h0000, 0, 1'b1, 32'b10110);
    chk("t6_toggles", 32'(TOGGLES), 32'(m_tog(3)));

    // stall pattern 1,0,0,1,1 with START pulses while busy
    valid4 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bits4  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_cnt4 = '{1, 1, 1, 2, 3};
    START = 1'b1; LEN = 16'd3; SEED = 16'hC001;
    @(posedge CK);
    @(negedge CK);
    s4 = 16'hC001;
    for (int i = 0; i < 5; i++) begin
      START = 1'b1; LEN = 16'd0; SEED = 16'hFFFF;
      VALID_IN = valid4[i];
      G17 = valid4[i] ? bits4[i] : 1'($urandom_range(1));
      @(posedge CK);
      @(negedge CK);
      if (valid4[i]) s4 = m_step(s4, bits4[i]);
      chk("t4_cnt", 32'(CNT), 32'(exp_cnt4[i]));
    end
    START = 1'b0; VALID_IN = 1'b0; GOLDEN = 16'h0BAD;
    chk("t4_busy_in_check", 32'(BUSY), 32'd1);
    chk("t4_no_early_done", 32'(DONE), 32'd0);
    exp_q.push_back('{sig: s4, pass: (s4 == 16'h0BAD), cnt: 16'd3, tog: m_tog(2)});
    @(posedge CK);
    @(negedge CK);
    chk("t4_done", 32'(DONE), 32'd1);

    // random sessions, back-to-back from the DONE cycle
    for (int k = 0; k < 25; k++) begin
      run_session(16'($urandom), int'($urandom_range(12)), int'($urandom_range(2)),
                  16'($urandom), 30, 1'b0, 32'h0);
    end
    run_session(16'($urandom), 200, 1, 16'h0, 10, 1'b0, 32'h0);

    // asynchronous reset mid-session
    START = 1'b1; LEN = 16'd5; SEED = 16'hFFFF;
    @(posedge CK);
    @(negedge CK);
    START = 1'b0; VALID_IN = 1'b1; G17 = 1'b1;
    repeat (2) @(posedge CK);
    @(negedge CK);
    VALID_IN = 1'b0;
    chk("t5_cnt_before", 32'(CNT), 32'd2);
    #2 RSTN = 1'b0;
    #1;
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_done", 32'(DONE), 32'd0);
    chk("t5_pass", 32'(PASS), 32'd0);
    chk("t5_sig",  32'(SIG),  32'd0);
    chk("t5_cnt",  32'(CNT),  32'd0);
    @(posedge CK);
    @(negedge CK);
    RSTN = 1'b1;
    VALID_IN = 1'b1;
    repeat (10) @(negedge CK);
    VALID_IN = 1'b0;
    chk("t5_idle_after_reset", 32'(BUSY), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
